// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encoding for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Decoder-based 1-bit full adder: one-hot minterm decode of {A,B,C},
// sum and carry are ORs of their minterm sets. Purely combinational.
module FA_Using_Dec (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic sum_o,
   output logic carry_o
);

   logic [7:0] dec;

   always_comb begin
      dec     = 8'b1 << {a_i, b_i, c_i};
      sum_o   = dec[1] | dec[2] | dec[4] | dec[7];
      carry_o = dec[3] | dec[5] | dec[6] | dec[7];
   end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: captures operands on start, adds LSB first
// through one full adder and a carry flop; done pulses in cycle WIDTH+1.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    count_q, count_d;
   logic             fa_sum, fa_carry;
   logic             load;

   FA_Using_Dec u_fa (
      .a_i     (a_sh_q[0]),
      .b_i     (b_sh_q[0]),
      .c_i     (carry_q),
      .sum_o   (fa_sum),
      .carry_o (fa_carry)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      count_d  = count_q;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) load = 1'b1;
         end
         ST_RUN: begin
            busy                = 1'b1;
            sum_sh_d            = sum_sh_q >> 1;
            sum_sh_d[WIDTH-1]   = fa_sum;
            a_sh_d              = a_sh_q >> 1;
            b_sh_d              = b_sh_q >> 1;
            carry_d             = fa_carry;
            count_d             = count_q + CW'(1);
            // The last bit lands in sum_sh_d this cycle, so publish that value directly.
            if (count_q == CW'(WIDTH - 1)) begin
               state_d = ST_DONE;
               sum_d   = sum_sh_d;
               cout_d  = fa_carry;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
            if (start) load = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         state_d  = ST_RUN;
         a_sh_d   = a;
         b_sh_d   = b;
         carry_d  = cin;
         count_d  = '0;
         sum_sh_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         count_q  <= count_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH 8, 4 and 1.
module tb_serial_adder_ctrl;

   logic clk, rst;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;
   logic       start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] s;
      logic       co;
   } vec_t;

   vec_t vecs[7];

   serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
   serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));
   serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a start for the 8-bit DUT; returns in cycle 1 with operands scrambled.
   task automatic do_start8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
      a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
      step();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
   endtask

   // From cycle 1, check the run phase and the done cycle; returns in the done cycle.
   task automatic wait_done8(input logic [7:0] es, input logic eco, input logic [7:0] hold);
      for (int i = 1; i <= 8; i++) begin
         chk("busy8_run", busy8, 1);
         chk("done8_run", done8, 0);
         chk("sum8_hold", sum8, hold);
         if (i < 8) step();
      end
      step();
      chk("done8_pulse", done8, 1);
      chk("busy8_done", busy8, 0);
      chk("sum8", sum8, es);
      chk("cout8", cout8, eco);
   endtask

   initial begin
      logic [7:0] prev;
      logic [4:0] exp5;
      int         lat;
      bit         saw_done;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
      vecs[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
      vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

      rst = 1'b1;
      start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
      start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
      start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
      repeat (2) step();
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_sum8", sum8, 0);
      chk("rst_cout8", cout8, 0);
      chk("rst_busy4", busy4, 0);
      chk("rst_sum1", {cout1, sum1}, 0);
      rst = 1'b0;
      step();

      prev = 8'h00;
      for (int v = 0; v < 7; v++) begin
         do_start8(vecs[v].a, vecs[v].b, vecs[v].cin);
         wait_done8(vecs[v].s, vecs[v].co, prev);
         prev = vecs[v].s;
         step();
         chk("done8_one_cycle", done8, 0);
         chk("busy8_idle", busy8, 0);
      end

      // start held during cycles 2-5 of a run must be ignored
      do_start8(8'h10, 8'h20, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         if (c == 2) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
         if (c == 6) start8 = 1'b0;
         chk("ign_busy8", busy8, 1);
         chk("ign_done8", done8, 0);
         step();
      end
      chk("ign_done_pulse", done8, 1);
      chk("ign_sum8", sum8, 8'h30);
      chk("ign_cout8", cout8, 0);
      step();
      chk("ign_idle", {busy8, done8}, 0);

      // reset in cycle 4 of a run aborts with no done pulse
      do_start8(8'h5A, 8'h3C, 1'b0);
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy8", busy8, 0);
      chk("abort_done8", done8, 0);
      chk("abort_sum8", sum8, 0);
      chk("abort_cout8", cout8, 0);
      saw_done = 0;
      for (int c = 0; c < 12; c++) begin
         if (done8) saw_done = 1;
         step();
      end
      chk("abort_no_done", saw_done, 0);

      // back-to-back: restart in the done cycle
      do_start8(8'h5A, 8'h3C, 1'b0);
      wait_done8(8'h96, 1'b0, 8'h00);
      do_start8(8'h80, 8'h80, 1'b0);
      wait_done8(8'h00, 1'b1, 8'h96);
      step();
      chk("b2b_idle", {busy8, done8}, 0);

      // WIDTH=4 exhaustive, each start issued in the previous done cycle
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
               step();
               start4 = 1'b0;
               a4 = ~a4; b4 = ~b4; cin4 = ~cin4;
               lat = 1;
               while (!done4 && lat < 12) begin
                  step();
                  lat++;
               end
               exp5 = 5'(ia + ib + ic);
               chk("w4_latency", lat, 5);
               chk("w4_result", {cout4, sum4}, exp5);
            end
         end
      end
      step();
      chk("w4_idle", {busy4, done4}, 0);

      // WIDTH=1: single RUN cycle
      a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
      step();
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
      chk("w1_busy_c1", busy1, 1);
      chk("w1_done_c1", done1, 0);
      step();
      chk("w1_done_c2", done1, 1);
      chk("w1_sum", sum1, 1);
      chk("w1_cout", cout1, 1);
      step();
      chk("w1_done_c3", done1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
